// File: rtl/cla_addsub_pipe_if.sv
// Operand/result bus for cla_addsub_pipe.
// Optional feature macro: COBALT_ADD_SAT_EN adds the 'sat' request bit.
//
// Handshake: a transfer on either side happens on a rising clk edge where
// valid and ready are both high. A producer holds valid and its data stable
// until that edge. A consumer may drive ready high or low in any cycle.
// in_ready never depends on in_valid.
interface cla_addsub_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;
`ifdef COBALT_ADD_SAT_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

`ifdef COBALT_ADD_SAT_EN
  modport master (output in_valid, a, b, cin, op_sub, sat, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf, zero);
  modport slave  (input  in_valid, a, b, cin, op_sub, sat, out_ready,
                  output in_ready, out_valid, sum, cout, ovf, zero);
`else
  modport master (output in_valid, a, b, cin, op_sub, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf, zero);
  modport slave  (input  in_valid, a, b, cin, op_sub, out_ready,
                  output in_ready, out_valid, sum, cout, ovf, zero);
`endif
endinterface

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor.
// Full lookahead inside each GROUP-bit group. Group carries ripple inside a stage.
// The inter-group chain is cut into STAGES register stages, so the latency is STAGES cycles.
// A single global advance signal stalls every stage together.
// Optional feature macro: COBALT_ADD_SAT_EN (saturating signed result on overflow).
// WIDTH must be a multiple of GROUP, and STAGES must divide WIDTH/GROUP.
module cla_addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input logic              clk,
  input logic              rst_n,
  cla_addsub_pipe_if.slave bus
);
  localparam int NG = WIDTH / GROUP;   // total lookahead groups
  localparam int N  = NG / STAGES;     // groups resolved per stage

  // One pipeline slot. The sum holds the finished low bits.
  // The p/g fields hold the bits still to be processed, and c is the pending carry.
  // ovf and zero are only meaningful in the last slot.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic             c;
    logic             ovf;
    logic             zero;
`ifdef COBALT_ADD_SAT_EN
    logic             sign;   // operand A sign, selects the clamp direction
    logic             sat;
`endif
  } stage_t;

  stage_t                head;    // freshly formed slot from the input bus
  stage_t [STAGES-1:0]   st_q;
  stage_t [STAGES-1:0]   st_d;
  stage_t [STAGES:0]     chain;   // chain[k] feeds stage k; chain[STAGES] is the output slot
  logic   [WIDTH-1:0]    b_eff;
  logic                  advance;

  assign chain   = {st_q, head};
  assign advance = !chain[STAGES].valid || bus.out_ready;

  assign bus.in_ready  = advance;
  assign bus.out_valid = chain[STAGES].valid;
  assign bus.sum       = chain[STAGES].sum;
  assign bus.cout      = chain[STAGES].c;
  assign bus.ovf       = chain[STAGES].ovf;
  assign bus.zero      = chain[STAGES].zero;

  // Form per-bit propagate/generate. Subtraction uses A + ~B + 1.
  always_comb begin
    head       = '0;
    b_eff      = bus.op_sub ? ~bus.b : bus.b;
    head.valid = bus.in_valid;
    head.p     = bus.a ^ b_eff;
    head.g     = bus.a & b_eff;
    head.c     = bus.op_sub | bus.cin;   // forced carry-in of 1 for subtract
`ifdef COBALT_ADD_SAT_EN
    head.sign  = bus.a[WIDTH-1];
    head.sat   = bus.sat;
`endif
  end

  // Each stage resolves its N groups. The last stage also derives ovf, the clamp and zero.
  always_comb begin
    stage_t           cur;
    logic [GROUP:0]   gc;
    logic [GROUP-1:0] gp;
    logic [GROUP-1:0] gg;
    logic             term;
    logic             cmsb;
    int               base;
    st_d = '0;
    cur  = '0;
    gc   = '0;
    gp   = '0;
    gg   = '0;
    term = 1'b0;
    cmsb = 1'b0;
    base = 0;
    for (int k = 0; k < STAGES; k++) begin
      cur = chain[k];
      for (int j = 0; j < N; j++) begin
        base = (k * N + j) * GROUP;
        gp   = cur.p[base +: GROUP];
        gg   = cur.g[base +: GROUP];
        // Each carry is a flat sum of products of the group's g/p and the group carry-in.
        for (int i = 0; i <= GROUP; i++) begin
          term = cur.c;
          for (int m = 0; m < i; m++) term = term & gp[m];
          gc[i] = term;
          for (int m = 0; m < i; m++) begin
            term = gg[m];
            for (int q = m + 1; q < i; q++) term = term & gp[q];
            gc[i] = gc[i] | term;
          end
        end
        cur.sum[base +: GROUP] = gp ^ gc[GROUP-1:0];
        cur.c = gc[GROUP];
        if (base + GROUP == WIDTH) cmsb = gc[GROUP-1];
      end
      if (k == STAGES - 1) begin
        cur.ovf = cmsb ^ cur.c;
`ifdef COBALT_ADD_SAT_EN
        if (cur.sat && cur.ovf)
          cur.sum = cur.sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        cur.zero = (cur.sum == '0);
      end
      st_d[k] = cur;
    end
  end

  // Pipeline registers: every stage moves together on advance and holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= '0;
    end else if (advance) begin
      st_q <= st_d;
    end
  end
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe (main instance STAGES=2, plus STAGES=8 and 1).
module tb_cla_addsub_pipe;
  localparam int W  = 32;
  localparam int ST = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cla_addsub_pipe_if #(.WIDTH(W)) bus2 ();
  cla_addsub_pipe_if #(.WIDTH(W)) bus8 ();
  cla_addsub_pipe_if #(.WIDTH(W)) bus1 ();

  cla_addsub_pipe #(.WIDTH(W), .GROUP(4), .STAGES(ST)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus2));
  cla_addsub_pipe #(.WIDTH(W), .GROUP(4), .STAGES(8))  dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  cla_addsub_pipe #(.WIDTH(W), .GROUP(4), .STAGES(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // ---------------- scoreboard ----------------
  logic [W+2:0] exp_q[$];   // {sum, cout, ovf, zero}
  int           acc_q[$];
  bit           lat_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic op_sub, input logic sat);
    logic [W:0]   full;
    logic [W-1:0] bx;
    logic [W-1:0] s;
    logic         ov;
    bx   = op_sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, (op_sub ? 1'b1 : cin)};
    s    = full[W-1:0];
    ov   = (a[W-1] == bx[W-1]) && (s[W-1] != a[W-1]);
`ifdef COBALT_ADD_SAT_EN
    if (sat && ov) s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
    if (sat) s = s;
`endif
    return {s, full[W], ov, (s == '0)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic op_sub, input logic sat, input bit lat);
    int waited;
    @(negedge clk);
    bus2.in_valid = 1'b1;
    bus2.a        = a;
    bus2.b        = b;
    bus2.cin      = cin;
    bus2.op_sub   = op_sub;
`ifdef COBALT_ADD_SAT_EN
    bus2.sat      = sat;
`endif
    #3;
    waited = 0;
    while (!bus2.in_ready && waited < 50) begin
      @(negedge clk);
      #3;
      waited++;
    end
    check("send_accept", bus2.in_ready, 1);
    if (bus2.in_ready) begin
      exp_q.push_back(model(a, b, cin, op_sub, sat));
      acc_q.push_back(cyc);
      lat_q.push_back(lat);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus2.in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- monitor ----------------
  bit           prev_stall = 1'b0;
  logic [W+2:0] prev_data;
  always begin
    logic [W+2:0] obs;
    logic [W+2:0] e;
    int           acc;
    bit           l;
    @(negedge clk);
    #3;
    if (rst_n === 1'b1) begin
      obs = {bus2.sum, bus2.cout, bus2.ovf, bus2.zero};
      check("in_ready_rule", bus2.in_ready, (!bus2.out_valid || bus2.out_ready));
      if (prev_stall) begin
        check("stall_valid_held", bus2.out_valid, 1);
        check("stall_data_held", obs, prev_data);
      end
      if (bus2.out_valid && bus2.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", bus2.out_valid, 0);
        end else begin
          e   = exp_q.pop_front();
          acc = acc_q.pop_front();
          l   = lat_q.pop_front();
          check("result", obs, e);
          if (l) check("latency", cyc - acc, ST);
        end
      end
      prev_stall = bus2.out_valid && !bus2.out_ready;
      prev_data  = obs;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat8, lat1;
    logic [W-1:0] s8, s1;
    logic c8, c1;
    rst_n = 1'b0;
    bus2.in_valid = 0; bus2.a = '0; bus2.b = '0; bus2.cin = 0; bus2.op_sub = 0; bus2.out_ready = 1;
    bus8.in_valid = 0; bus8.a = '0; bus8.b = '0; bus8.cin = 0; bus8.op_sub = 0; bus8.out_ready = 1;
    bus1.in_valid = 0; bus1.a = '0; bus1.b = '0; bus1.cin = 0; bus1.op_sub = 0; bus1.out_ready = 1;
`ifdef COBALT_ADD_SAT_EN
    bus2.sat = 0; bus8.sat = 0; bus1.sat = 0;
`endif
    repeat (3) @(negedge clk);
    check("rst_out_valid", bus2.out_valid, 0);
    check("rst_sum", bus2.sum, 0);
    check("rst_flags", {bus2.cout, bus2.ovf, bus2.zero}, 3'b000);
    rst_n = 1'b1;

    // add wrap to zero, then the two subtract cases
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1); idle(); drain(20);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 1'b1); idle(); drain(20);
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0, 1'b1); idle(); drain(20);
    send(32'h0FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1); idle(); drain(20);

    // back-to-back stream with a three-cycle downstream stall
    fork
      begin
        for (int i = 1; i <= 8; i++) send(i, i, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        bus2.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        bus2.out_ready = 1'b1;
      end
    join
    drain(40);

    // carry ripple across every group at STAGES=8 and STAGES=1
    @(negedge clk);
    bus8.in_valid = 1; bus8.a = 32'h0FFF_FFFF; bus8.b = '0; bus8.cin = 1; bus8.op_sub = 0;
    bus1.in_valid = 1; bus1.a = 32'h0FFF_FFFF; bus1.b = '0; bus1.cin = 1; bus1.op_sub = 0;
    #3;
    check("s8_in_ready", bus8.in_ready, 1);
    check("s1_in_ready", bus1.in_ready, 1);
    lat8 = -1; lat1 = -1; s8 = '0; s1 = '0; c8 = 1'b1; c1 = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      bus8.in_valid = 0;
      bus1.in_valid = 0;
      if (bus8.out_valid && lat8 < 0) begin lat8 = n; s8 = bus8.sum; c8 = bus8.cout; end
      if (bus1.out_valid && lat1 < 0) begin lat1 = n; s1 = bus1.sum; c1 = bus1.cout; end
    end
    check("s8_latency", lat8, 8);
    check("s8_sum", s8, 32'h1000_0000);
    check("s8_cout", c8, 0);
    check("s1_latency", lat1, 1);
    check("s1_sum", s1, 32'h1000_0000);
    check("s1_cout", c1, 0);

    // random traffic with random downstream readiness
    fork
      begin
        for (int i = 0; i < 24; i++)
          send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        idle();
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          bus2.out_ready = 1'($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        bus2.out_ready = 1'b1;
      end
    join
    drain(60);

    // asynchronous reset with two operations in flight
    send(32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'd5, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("pre_rst_valid", bus2.out_valid, 1);
    #1;
    bus2.in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    lat_q.delete();
    #1;
    check("async_rst_valid", bus2.out_valid, 0);
    check("async_rst_sum", bus2.sum, 0);
    check("async_rst_flags", {bus2.cout, bus2.ovf, bus2.zero}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    send(32'd3, 32'd4, 1'b0, 1'b0, 1'b0, 1'b1); idle(); drain(20);

`ifdef COBALT_ADD_SAT_EN
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b1); idle(); drain(20);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1); idle(); drain(20);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b1); idle(); drain(20);
`endif

    repeat (4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
